handshake_bus_cdc_rx: RTL

- Receiving end of a toggle req/ack bus-crossing protocol.
- Upstream holds `up_bus` stable and toggles `up_req_tgl`. This block synchronizes the toggle, captures the bus and presents it as a valid/ready stream in the `dn_clk` domain.
- It returns `dn_ack_tgl` once the word is consumed.
- Unlike the lossy continuous crossing, every word is delivered exactly once.

---
 rtl/handshake_bus_cdc_rx_pkg.sv | 9 +
 rtl/handshake_bus_cdc_rx_bit_sync.sv | 22 ++
 rtl/handshake_bus_cdc_rx.sv | 93 +++++++++
 3 files changed

// File: rtl/handshake_bus_cdc_rx_pkg.sv
// Shared types and limits for the toggle req/ack bus-crossing receiver.
package cdc_pkg;

  typedef enum logic {RX_IDLE, RX_HOLD} cdc_rx_state_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

endpackage

// File: rtl/handshake_bus_cdc_rx_bit_sync.sv
// N-flop single-bit synchronizer. There is no logic between the stages.
// The matching transmitter can reuse it on the ack toggle.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Plain shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/handshake_bus_cdc_rx.sv
// Receiving end of a toggle req/ack bus crossing.
// The block synchronizes up_req_tgl and captures up_bus once per request.
// It presents the captured word as a valid/ready stream and returns
// dn_ack_tgl after the word is consumed.
// Optional: `define HANDSHAKE_CDC_RX_OVERRUN_EN enables the sticky dn_overrun
// flag. That flag flags a request toggle seen while a word is still held.
module handshake_bus_cdc_rx
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 dn_clk,
  input  logic                 dn_rst_n,
  input  logic                 up_req_tgl,
  input  logic [BUS_WIDTH-1:0] up_bus,
  output logic                 dn_ack_tgl,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [BUS_WIDTH-1:0] dn_data,
  output logic                 dn_overrun
);

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
      $error("handshake_bus_cdc_rx: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic          req_s;
  logic          req_seen;
  logic          new_req;
  cdc_rx_state_e state;

  bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (dn_clk),
    .rst_n (dn_rst_n),
    .d     (up_req_tgl),
    .q     (req_s)
  );

  // A request is pending whenever the synchronized toggle differs from the last one taken.
  assign new_req = req_s ^ req_seen;

  // Capture/hold FSM. req_seen only advances on capture, so a toggle during HOLD
  // is picked up on return to IDLE. A double toggle cancels out.
  always_ff @(posedge dn_clk or negedge dn_rst_n) begin
    if (!dn_rst_n) begin
      state      <= RX_IDLE;
      req_seen   <= 1'b0;
      dn_valid   <= 1'b0;
      dn_data    <= '0;
      dn_ack_tgl <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (new_req) begin
            dn_data  <= up_bus;
            req_seen <= req_s;
            dn_valid <= 1'b1;
            state    <= RX_HOLD;
          end
        end
        RX_HOLD: begin
          if (dn_valid && dn_ready) begin
            dn_valid   <= 1'b0;
            dn_ack_tgl <= ~dn_ack_tgl;
            state      <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

`ifdef HANDSHAKE_CDC_RX_OVERRUN_EN
  logic req_s_d;

  // Any movement of the synchronized request while holding a word is an upstream protocol error.
  always_ff @(posedge dn_clk or negedge dn_rst_n) begin
    if (!dn_rst_n) begin
      req_s_d    <= 1'b0;
      dn_overrun <= 1'b0;
    end else begin
      req_s_d <= req_s;
      if (state == RX_HOLD && req_s != req_s_d) dn_overrun <= 1'b1;
    end
  end
`else
  assign dn_overrun = 1'b0;
`endif

endmodule
